// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: words, ALU ops, immediate-extension modes and the
// ID/EX held-operand record.
package cpu_types_pkg;
    localparam int CPU_WORD_W = 32;
    localparam int CPU_REG_W  = 5;

    typedef logic [CPU_WORD_W-1:0] word_t;
    typedef logic [CPU_REG_W-1:0]  regbits_t;

    typedef enum logic [3:0] {
        ALU_SLL, ALU_SRL, ALU_ADD, ALU_SUB, ALU_AND,
        ALU_OR,  ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU
    } aluop_t;

    typedef enum logic [1:0] {
        EXT_ZEXT = 2'd0,
        EXT_SEXT = 2'd1,
        EXT_LUI  = 2'd2
    } extop_t;

    typedef struct packed {
        regbits_t    rs;
        regbits_t    rt;
        word_t       rdat1;
        word_t       rdat2;
        logic [15:0] imm16;
        extop_t      extop;
        logic        alusrc;
        aluop_t      aluop;
        regbits_t    wsel;
        logic        regwen;
    } ex_operand_t;

    // Unused encoding 3 falls back to zero extension.
    function automatic word_t ext_imm(input logic [15:0] imm, input extop_t op);
        case (op)
            EXT_SEXT: ext_imm = {{16{imm[15]}}, imm};
            EXT_LUI:  ext_imm = {imm, 16'b0};
            default:  ext_imm = {16'b0, imm};
        endcase
    endfunction
endpackage

// File: rtl/operand_fwd_mux.sv
// Per-operand bypass select: EX/MEM (non-load) beats MEM/WB beats held data;
// register 0 is hardwired to zero.
module operand_fwd_mux #(
    parameter int WORD_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] idx,
    input  logic [WORD_W-1:0]     held,
    input  logic                  exmem_wen,
    input  logic [REG_ADDR_W-1:0] exmem_wsel,
    input  logic [WORD_W-1:0]     exmem_wdat,
    input  logic                  exmem_load,
    input  logic                  memwb_wen,
    input  logic [REG_ADDR_W-1:0] memwb_wsel,
    input  logic [WORD_W-1:0]     memwb_wdat,
    output logic [WORD_W-1:0]     fwd
);
    logic exmem_hit, memwb_hit;

    // A load in EX/MEM has no data yet; the hazard logic stalls instead.
    assign exmem_hit = exmem_wen && !exmem_load && (exmem_wsel == idx);
    assign memwb_hit = memwb_wen && (memwb_wsel == idx);

    always_comb begin
        fwd = held;
        if (idx == '0)     fwd = '0;
        else if (exmem_hit) fwd = exmem_wdat;
        else if (memwb_hit) fwd = memwb_wdat;
    end
endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX operand stage: holds one decoded instruction, forwards operands from
// EX/MEM and MEM/WB, extends the immediate and stalls on load-use hazards.
module ex_operand_stage
    import cpu_types_pkg::*;
#(
    parameter int WORD_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [REG_ADDR_W-1:0] in_rs,
    input  logic [REG_ADDR_W-1:0] in_rt,
    input  logic [WORD_W-1:0]     in_rdat1,
    input  logic [WORD_W-1:0]     in_rdat2,
    input  logic [15:0]           in_imm16,
    input  extop_t                in_extop,
    input  logic                  in_alusrc,
    input  aluop_t                in_aluop,
    input  logic [REG_ADDR_W-1:0] in_wsel,
    input  logic                  in_regwen,
    input  logic                  exmem_wen,
    input  logic [REG_ADDR_W-1:0] exmem_wsel,
    input  logic [WORD_W-1:0]     exmem_wdat,
    input  logic                  exmem_load,
    input  logic                  memwb_wen,
    input  logic [REG_ADDR_W-1:0] memwb_wsel,
    input  logic [WORD_W-1:0]     memwb_wdat,
    input  logic                  alu_ready,
    output logic                  ex_valid,
    output logic [WORD_W-1:0]     porta,
    output logic [WORD_W-1:0]     portb,
    output aluop_t                aluop,
    output logic [REG_ADDR_W-1:0] ex_wsel,
    output logic                  ex_regwen
);
    ex_operand_t         q;
    logic                valid_q;
    logic                hazard, fire, accept;
    logic [WORD_W-1:0]   fwd_rs, fwd_rt, cap1, cap2;
    logic                wb_rs, wb_rt, wb_in_rs, wb_in_rt;

    assign hazard = valid_q && exmem_load && exmem_wen && (exmem_wsel != '0) &&
                    ((exmem_wsel == q.rs) || (!q.alusrc && (exmem_wsel == q.rt)));
    assign ex_valid = valid_q && !hazard;
    assign fire     = ex_valid && alu_ready;
    assign in_ready = !valid_q || fire;
    assign accept   = in_valid && in_ready && !flush;

    assign wb_rs    = memwb_wen && (memwb_wsel != '0) && (memwb_wsel == q.rs);
    assign wb_rt    = memwb_wen && (memwb_wsel != '0) && (memwb_wsel == q.rt);
    assign wb_in_rs = memwb_wen && (memwb_wsel != '0) && (memwb_wsel == in_rs);
    assign wb_in_rt = memwb_wen && (memwb_wsel != '0) && (memwb_wsel == in_rt);

    // Regfile write and read land in the same cycle, so bypass WB at capture.
    assign cap1 = wb_in_rs ? memwb_wdat : in_rdat1;
    assign cap2 = wb_in_rt ? memwb_wdat : in_rdat2;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            q       <= '0;
            valid_q <= 1'b0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (accept) begin
            q.rs     <= in_rs;
            q.rt     <= in_rt;
            q.rdat1  <= cap1;
            q.rdat2  <= cap2;
            q.imm16  <= in_imm16;
            q.extop  <= in_extop;
            q.alusrc <= in_alusrc;
            q.aluop  <= in_aluop;
            q.wsel   <= in_wsel;
            q.regwen <= in_regwen;
            valid_q  <= 1'b1;
        end else if (fire) begin
            valid_q <= 1'b0;
        end else if (valid_q) begin
            // A WB value retiring during a stall would otherwise be lost.
            if (wb_rs) q.rdat1 <= memwb_wdat;
            if (wb_rt) q.rdat2 <= memwb_wdat;
        end
    end

    operand_fwd_mux #(.WORD_W(WORD_W), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rs (
        .idx(q.rs), .held(q.rdat1),
        .exmem_wen(exmem_wen), .exmem_wsel(exmem_wsel), .exmem_wdat(exmem_wdat),
        .exmem_load(exmem_load),
        .memwb_wen(memwb_wen), .memwb_wsel(memwb_wsel), .memwb_wdat(memwb_wdat),
        .fwd(fwd_rs)
    );

    operand_fwd_mux #(.WORD_W(WORD_W), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rt (
        .idx(q.rt), .held(q.rdat2),
        .exmem_wen(exmem_wen), .exmem_wsel(exmem_wsel), .exmem_wdat(exmem_wdat),
        .exmem_load(exmem_load),
        .memwb_wen(memwb_wen), .memwb_wsel(memwb_wsel), .memwb_wdat(memwb_wdat),
        .fwd(fwd_rt)
    );

    assign porta     = fwd_rs;
    assign portb     = q.alusrc ? ext_imm(q.imm16, q.extop) : fwd_rt;
    assign aluop     = q.aluop;
    assign ex_wsel   = q.wsel;
    assign ex_regwen = q.regwen;
endmodule

// File: tb/tb_ex_operand_stage.sv
// Scoreboard bench for ex_operand_stage: directed issues push expected operands,
// a negedge monitor pops and compares on every ALU handshake.
module tb_ex_operand_stage;
    import cpu_types_pkg::*;

    logic        CLK = 1'b0;
    logic        nRST, flush, in_valid, in_ready;
    logic [4:0]  in_rs, in_rt, in_wsel, exmem_wsel, memwb_wsel, ex_wsel;
    logic [31:0] in_rdat1, in_rdat2, exmem_wdat, memwb_wdat, porta, portb;
    logic [15:0] in_imm16;
    extop_t      in_extop;
    aluop_t      in_aluop, aluop;
    logic        in_alusrc, in_regwen, exmem_wen, exmem_load, memwb_wen;
    logic        alu_ready, ex_valid, ex_regwen;

    always #5 CLK = ~CLK;

    ex_operand_stage dut (
        .CLK(CLK), .nRST(nRST), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_rs(in_rs), .in_rt(in_rt), .in_rdat1(in_rdat1), .in_rdat2(in_rdat2),
        .in_imm16(in_imm16), .in_extop(in_extop), .in_alusrc(in_alusrc),
        .in_aluop(in_aluop), .in_wsel(in_wsel), .in_regwen(in_regwen),
        .exmem_wen(exmem_wen), .exmem_wsel(exmem_wsel), .exmem_wdat(exmem_wdat),
        .exmem_load(exmem_load), .memwb_wen(memwb_wen), .memwb_wsel(memwb_wsel),
        .memwb_wdat(memwb_wdat), .alu_ready(alu_ready), .ex_valid(ex_valid),
        .porta(porta), .portb(portb), .aluop(aluop), .ex_wsel(ex_wsel),
        .ex_regwen(ex_regwen)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [4:0]  ws;
        logic        rw;
    } exp_t;

    exp_t sbq[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every handshake must match the oldest expected issue.
    always @(negedge CLK) begin
        if (nRST && ex_valid && alu_ready) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_issue: got porta=%h portb=%h expected none", porta, portb);
            end else begin
                e = sbq.pop_front();
                chk("sb_porta", porta, e.a);
                chk("sb_portb", portb, e.b);
                chk("sb_aluop", {28'b0, aluop}, {28'b0, e.op});
                chk("sb_wsel", {27'b0, ex_wsel}, {27'b0, e.ws});
                chk("sb_regwen", {31'b0, ex_regwen}, {31'b0, e.rw});
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic issue(input logic [4:0] rs, input logic [31:0] d1,
                         input logic [4:0] rt, input logic [31:0] d2,
                         input logic [15:0] imm, input extop_t ext, input logic src,
                         input aluop_t op, input logic [4:0] ws, input logic rw);
        in_valid = 1'b1; in_rs = rs; in_rdat1 = d1; in_rt = rt; in_rdat2 = d2;
        in_imm16 = imm; in_extop = ext; in_alusrc = src; in_aluop = op;
        in_wsel = ws; in_regwen = rw;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] b, input aluop_t op,
                        input logic [4:0] ws, input logic rw);
        exp_t x;
        x.a = a; x.b = b; x.op = op; x.ws = ws; x.rw = rw;
        sbq.push_back(x);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        extop_t      exts[4];
        logic [31:0] immx[4];
        exts[0] = EXT_SEXT; immx[0] = 32'hFFFF8001;
        exts[1] = EXT_ZEXT; immx[1] = 32'h00008001;
        exts[2] = EXT_LUI;  immx[2] = 32'h80010000;
        exts[3] = extop_t'(2'd3); immx[3] = 32'h00008001;

        nRST = 0; flush = 0; in_valid = 0; in_rs = 0; in_rt = 0; in_rdat1 = 0;
        in_rdat2 = 0; in_imm16 = 0; in_extop = EXT_ZEXT; in_alusrc = 0;
        in_aluop = ALU_SLL; in_wsel = 0; in_regwen = 0; exmem_wen = 0; exmem_wsel = 0;
        exmem_wdat = 0; exmem_load = 0; memwb_wen = 0; memwb_wsel = 0; memwb_wdat = 0;
        alu_ready = 1;

        // Reset state
        repeat (2) @(posedge CLK);
        #1 nRST = 1;
        @(negedge CLK);
        chk("rst_ex_valid", {31'b0, ex_valid}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_porta", porta, 32'd0);
        chk("rst_portb", portb, 32'd0);
        chk("rst_aluop", {28'b0, aluop}, 32'd0);
        chk("rst_ex_wsel", {27'b0, ex_wsel}, 32'd0);
        chk("rst_ex_regwen", {31'b0, ex_regwen}, 32'd0);

        // Plain accept, one-cycle latency
        step();
        issue(3, 32'd5, 4, 32'd7, 16'h0, EXT_ZEXT, 0, ALU_ADD, 10, 1);
        push(32'd5, 32'd7, ALU_ADD, 10, 1);
        step();
        in_valid = 0;
        @(negedge CLK);
        step();

        // Forwarding priority with a stalled ALU
        issue(3, 32'h11, 4, 32'h22, 16'h0, EXT_ZEXT, 0, ALU_OR, 12, 1);
        alu_ready = 0;
        step();
        in_valid = 0;
        exmem_wen = 1; exmem_wsel = 0; exmem_wdat = 32'hAA;
        memwb_wen = 1; memwb_wsel = 0; memwb_wdat = 32'hBB;
        @(negedge CLK);
        chk("r0_write_ignored_porta", porta, 32'h11);
        chk("held_in_ready", {31'b0, in_ready}, 32'd0);
        step();
        exmem_wsel = 3; memwb_wsel = 3;
        @(negedge CLK);
        chk("fwd_exmem_over_memwb", porta, 32'hAA);
        chk("fwd_rt_untouched", portb, 32'h22);
        step();
        // WB wrote r3 while stalled: the held value must now be 0xBB.
        exmem_wen = 0; memwb_wen = 0; alu_ready = 1;
        push(32'hBB, 32'h22, ALU_OR, 12, 1);
        @(negedge CLK);
        step();

        // Load-use stall then WB delivery
        issue(8, 32'h99, 9, 32'h0, 16'h0005, EXT_ZEXT, 1, ALU_ADD, 13, 1);
        step();
        in_valid = 0;
        exmem_load = 1; exmem_wen = 1; exmem_wsel = 8; exmem_wdat = 32'hDEAD;
        @(negedge CLK);
        chk("loaduse_ex_valid", {31'b0, ex_valid}, 32'd0);
        chk("loaduse_in_ready", {31'b0, in_ready}, 32'd0);
        step();
        exmem_load = 0; exmem_wen = 0;
        memwb_wen = 1; memwb_wsel = 8; memwb_wdat = 32'h1234;
        push(32'h1234, 32'd5, ALU_ADD, 13, 1);
        @(negedge CLK);
        step();
        memwb_wen = 0;

        // Immediate extension, back-to-back issues; rs=0 reads zero
        for (int i = 0; i < 4; i++) begin
            issue(0, 32'h77, 0, 32'h0, 16'h8001, exts[i], 1, ALU_OR, 5'(i + 1), 0);
            push(32'h0, immx[i], ALU_OR, 5'(i + 1), 0);
            step();
        end
        in_valid = 0;
        @(negedge CLK);
        step();

        // Flush squashes both held and incoming instructions
        issue(2, 32'h21, 0, 32'h0, 16'h0, EXT_ZEXT, 0, ALU_AND, 14, 1);
        alu_ready = 0;
        step();
        issue(1, 32'h31, 0, 32'h0, 16'h0, EXT_ZEXT, 0, ALU_XOR, 15, 1);
        flush = 1;
        @(negedge CLK);
        chk("flush_in_ready_preflush", {31'b0, in_ready}, 32'd0);
        step();
        flush = 0; in_valid = 0;
        @(negedge CLK);
        chk("flush_ex_valid", {31'b0, ex_valid}, 32'd0);
        chk("flush_in_ready", {31'b0, in_ready}, 32'd1);
        step();

        // Outputs stable across a 3-cycle downstream stall
        issue(5, 32'h55, 6, 32'h66, 16'h0, EXT_ZEXT, 0, ALU_SUB, 7, 1);
        step();
        in_valid = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            chk("hold_ex_valid", {31'b0, ex_valid}, 32'd1);
            chk("hold_porta", porta, 32'h55);
            chk("hold_portb", portb, 32'h66);
            chk("hold_aluop", {28'b0, aluop}, {28'b0, ALU_SUB});
            chk("hold_ex_wsel", {27'b0, ex_wsel}, 32'd7);
            step();
        end
        alu_ready = 1;
        push(32'h55, 32'h66, ALU_SUB, 7, 1);
        @(negedge CLK);
        step();

        // Reset mid-stall drops the held instruction
        issue(9, 32'h9, 10, 32'hA, 16'h0, EXT_ZEXT, 0, ALU_SLT, 3, 1);
        alu_ready = 0;
        step();
        in_valid = 0; nRST = 0;
        step();
        nRST = 1;
        @(negedge CLK);
        chk("midrst_ex_valid", {31'b0, ex_valid}, 32'd0);
        chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
        alu_ready = 1;
        step();

        chk("sb_drained", sbq.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
